// File: rtl/ibus_lane_rx.sv
// ibus_lane_rx: deserialises strobe-framed words from the two-lane iBus,
// checks even parity and frame length, and buffers good words in a FIFO.
module ibus_lane_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  ibus,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BC_W  = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_PAR,
        S_STOP,
        S_DRAIN
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   shreg_q;
    logic [BC_W-1:0]     bitcnt_q;
    logic                par_q;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_d;
    logic [DATA_W-1:0]   head_d;

    logic lane;
    logic strobe;
    logic wr_req;
    logic pop;
    logic full;
    logic wr_acc;
    logic ovf_c;

    assign lane   = ibus[0];
    assign strobe = ibus[1];

    // A completed frame with the strobe back low and even parity is a write request.
    assign wr_req = (state_q == S_STOP) && !strobe && !(^{shreg_q, par_q});
    assign pop    = rx_valid && rx_ready;
    assign full   = (fifo_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO can still take the word.
    assign wr_acc = wr_req && (!full || pop);
    assign ovf_c  = wr_req && full && !pop;

    // Frame FSM: sampling, framing checks and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            par_q      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (strobe) begin
                        shreg_q  <= {shreg_q[DATA_W-2:0], lane};
                        bitcnt_q <= BC_W'(1);
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!strobe) begin
                        frame_err <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        shreg_q  <= {shreg_q[DATA_W-2:0], lane};
                        bitcnt_q <= bitcnt_q + BC_W'(1);
                        if (bitcnt_q == BC_W'(DATA_W - 1)) begin
                            state_q <= S_PAR;
                        end
                    end
                end
                S_PAR: begin
                    if (!strobe) begin
                        frame_err <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        par_q   <= lane;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (strobe) begin
                        frame_err <= 1'b1;
                        state_q   <= S_DRAIN;
                    end else begin
                        parity_err <= ^{shreg_q, par_q};
                        state_q    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (!strobe) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Next pointers, occupancy and the head word seen after this edge.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        count_d  = fifo_count;
        if (wr_acc && !pop) begin
            count_d = fifo_count + CNT_W'(1);
        end else if (!wr_acc && pop) begin
            count_d = fifo_count - CNT_W'(1);
        end
        head_d = rx_data;
        if (count_d != '0) begin
            // The word being written becomes the head only when nothing else remains.
            if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
                head_d = shreg_q;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

    // FIFO control and registered output side.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_count <= count_d;
            rx_data    <= head_d;
            rx_valid   <= (count_d != '0);
            overflow   <= ovf_c;
        end
    end

endmodule

// File: tb/tb_ibus_lane_rx.sv
// Directed bench for ibus_lane_rx with a word scoreboard and pulse counters.
module tb_ibus_lane_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ibus;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int par_cnt  = 0;
    int frm_cnt  = 0;
    int ovf_cnt  = 0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ibus_lane_rx #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ibus       (ibus),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Count error pulses per cycle and compare every accepted word to the scoreboard.
    always @(negedge clk) begin
        if (parity_err === 1'b1) par_cnt++;
        if (frame_err === 1'b1) frm_cnt++;
        if (overflow === 1'b1) ovf_cnt++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            chk("sb_has_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("sb_word", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe high for nhigh cycles: 8 payload bits MSB first, parity, then zeros.
    task automatic drive_high(input logic [7:0] d, input logic p, input int nhigh);
        logic [7:0] sh;
        logic       b;
        sh = d;
        for (int i = 0; i < nhigh; i++) begin
            if (i < 8) begin
                b  = sh[7];
                sh = sh << 1;
            end else if (i == 8) begin
                b = p;
            end else begin
                b = 1'b0;
            end
            ibus = {1'b1, b};
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int nhigh);
        drive_high(d, p, nhigh);
        ibus = 2'b00;
        tick();
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back(d);
        send_frame(d, ^d, 9);
    endtask

    initial begin
        rst      = 1'b1;
        ibus     = 2'b00;
        rx_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Single good word; visible two cycles after the parity cycle.
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        drive_high(8'hA5, 1'b0, 9);
        chk("t1_valid_in_stop", 32'(rx_valid), 32'd0);
        ibus = 2'b00;
        tick();
        chk("t1_valid", 32'(rx_valid), 32'd1);
        chk("t1_data", 32'(rx_data), 32'hA5);
        chk("t1_count1", 32'(fifo_count), 32'd1);
        tick();
        chk("t1_valid_drop", 32'(rx_valid), 32'd0);
        chk("t1_count0", 32'(fifo_count), 32'd0);
        chk("t1_no_errs", 32'(par_cnt + frm_cnt + ovf_cnt), 32'd0);

        // Good parity then bad parity on the same payload.
        send_good(8'h07);
        send_frame(8'h07, 1'b0, 9);
        tick();
        chk("t2_perr", 32'(par_cnt), 32'd1);
        chk("t2_ferr", 32'(frm_cnt), 32'd0);
        chk("t2_valid", 32'(rx_valid), 32'd0);
        chk("t2_count", 32'(fifo_count), 32'd0);

        // Short frame, overlong frame, then a clean word.
        send_frame(8'h3C, 1'b0, 5);
        tick();
        chk("t3_short_ferr", 32'(frm_cnt), 32'd1);
        chk("t3_short_count", 32'(fifo_count), 32'd0);
        send_frame(8'h3C, 1'b0, 12);
        tick();
        chk("t3_long_ferr", 32'(frm_cnt), 32'd2);
        chk("t3_long_perr", 32'(par_cnt), 32'd1);
        chk("t3_long_count", 32'(fifo_count), 32'd0);
        send_good(8'h3C);
        repeat (2) tick();
        chk("t3_good_count", 32'(fifo_count), 32'd0);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Fill with no consumer; the fifth word overflows.
        rx_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            logic [7:0] w;
            w = 8'(k);
            if (k <= 4) exp_q.push_back(w);
            send_frame(w, ^w, 9);
        end
        tick();
        chk("t4_count_full", 32'(fifo_count), 32'd4);
        chk("t4_ovf", 32'(ovf_cnt), 32'd1);
        chk("t4_valid", 32'(rx_valid), 32'd1);
        chk("t4_head_held", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        repeat (6) tick();
        chk("t4_drained", 32'(fifo_count), 32'd0);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_ovf_once", 32'(ovf_cnt), 32'd1);

        // Full FIFO with a pop in the write cycle: write accepted, no overflow.
        rx_ready = 1'b0;
        send_good(8'h11);
        send_good(8'h22);
        send_good(8'h33);
        send_good(8'h44);
        chk("t5_full", 32'(fifo_count), 32'd4);
        exp_q.push_back(8'h99);
        drive_high(8'h99, ^(8'h99), 9);
        ibus     = 2'b00;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t5_count_kept", 32'(fifo_count), 32'd4);
        chk("t5_head_next", 32'(rx_data), 32'h22);
        tick();
        chk("t5_no_ovf", 32'(ovf_cnt), 32'd1);
        rx_ready = 1'b1;
        repeat (6) tick();
        chk("t5_drained", 32'(fifo_count), 32'd0);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the fourth payload bit with the strobe still high.
        ibus = 2'b11;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", 32'(rx_valid), 32'd0);
        chk("t6_data", 32'(rx_data), 32'd0);
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_errs", 32'({parity_err, frame_err, overflow}), 32'd0);
        repeat (5) tick();
        ibus = 2'b00;
        tick();
        tick();
        chk("t6_restart_ferr", 32'(frm_cnt), 32'd3);
        chk("t6_perr_same", 32'(par_cnt), 32'd1);
        send_good(8'h5A);
        repeat (2) tick();
        chk("t6_count", 32'(fifo_count), 32'd0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibus_lane_rx.md
Name: ibus_lane_rx

Overview:
- Receiving end of the two-lane generic interconnect bus iBus[0:1]. The driver side serialises words onto this bus.
- Lane 0 carries data, MSB first. Lane 1 carries the frame strobe.
- The block deserialises frames, checks even parity and framing, and buffers good words in a small FIFO with a valid/ready output.
- It sits between the interconnect bus and the module that consumes the words.

Parameters:
- DATA_W, 8, payload bits per frame (≥2).
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ibus  input  2  ibus[0] = serial data lane, ibus[1] = frame strobe. Both are synchronous to clk.
- rx_data  output  DATA_W  word at the FIFO head.
- rx_valid  output  1  FIFO is not empty.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- parity_err  output  1  one-cycle pulse: frame had bad parity and was discarded.
- frame_err  output  1  one-cycle pulse: frame was short or overlong and was discarded.
- overflow  output  1  one-cycle pulse: good frame arrived while the FIFO was full and was dropped.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; shift register, bit counter and FIFO pointers are cleared.
  - rx_valid=0, rx_data=0, fifo_count=0, all error pulses 0.
  - Reset mid-frame discards the partial frame with no error pulse.
  - After reset releases, a strobe that is already high is treated as a new frame start.
- Frame format: strobe high for exactly DATA_W+1 consecutive cycles, then low for at least 1 cycle.
  - The DATA_W high cycles sample payload bits MSB first; the next high cycle samples the parity bit.
  - Even parity: XOR of payload and parity bit must equal 0.
- FSM states:
  - IDLE: if strobe=1, capture lane0 as bit DATA_W-1, set bitcnt=1, go to SHIFT.
  - SHIFT: if strobe=0, pulse frame_err and go to IDLE. Otherwise shift lane0 in and increment bitcnt; when bitcnt reaches DATA_W, go to PAR.
  - PAR: if strobe=0, pulse frame_err and go to IDLE. Otherwise latch lane0 as the parity bit and go to STOP.
  - STOP: if strobe=1 (overlong), pulse frame_err and go to DRAIN. If strobe=0:
    - bad parity: pulse parity_err, go to IDLE.
    - good parity: write the word to the FIFO (or pulse overflow if it cannot be accepted), go to IDLE.
  - DRAIN: stay until strobe=0, then go to IDLE. No error is pulsed again in DRAIN.
- Error priority in STOP: frame_err takes precedence over parity_err. At most one error pulse per frame.
- Back-to-back frames: a one-cycle low gap is sufficient. The strobe may go high in the cycle immediately after STOP.
- FIFO and output timing:
  - The write happens in the STOP cycle; rx_valid is high from the next cycle. Latency from the parity-bit cycle to rx_valid is 2 cycles.
  - rx_data is a registered FIFO head and is held stable while rx_valid && !rx_ready.
  - The pop happens on the cycle where rx_valid && rx_ready.
- Full and simultaneous events:
  - Write while full with a pop in the same cycle: the write is accepted, count is unchanged, no overflow.
  - Write while full with no pop: word dropped, overflow pulses, FIFO contents are untouched.
  - Write and pop in the same cycle on a non-empty, non-full FIFO: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH and never wraps.
- When empty, rx_ready is ignored. rx_data keeps its last value and is don't-care when rx_valid=0.

Test Plan:
- Reset, then send 0xA5 with parity 0, rx_ready=1 → rx_valid rises 2 cycles after the parity cycle with rx_data=0xA5 for 1 cycle; no error pulses; fifo_count returns 0.
- Send 0x07 with parity 1, then 0x07 with parity 0 → first frame delivered as 0x07; second produces a single parity_err pulse with rx_valid staying 0.
- Strobe drops after 5 payload bits; separately, strobe stays high for 12 cycles → exactly one frame_err pulse for each case, no FIFO write, the next valid 0x3C is received correctly.
- rx_ready=0, send 0x01..0x05 back-to-back with 1-cycle gaps → fifo_count=4, overflow pulses once on the 5th frame; raising rx_ready yields 0x01,0x02,0x03,0x04 in order.
- FIFO full (count=4), pop on the same cycle as the STOP of 0x99 → no overflow, count stays 4, 0x99 emerges last.
- Assert rst for 1 cycle in the middle of the 4th payload bit, strobe still high → all outputs 0; the remaining high cycles are treated as a new frame start (which then produces frame_err); a clean 0x5A after that is delivered correctly.
